instr_prefetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the IF/ID pipeline register. It generates sequential fetch addresses to instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs in a small FIFO. It feeds decode through a valid/ready port. Taken-branch redirects from the MEM stage flush it, and it discards stale in-flight responses.

---
 rtl/instr_prefetch_queue.sv | 94 +++++++++
 tb/tb_instr_prefetch_queue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID: sequential fetch over req/gnt/rvalid,
// a small PC+instruction FIFO, and redirect flush with stale-response discard.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [63:0]   fetch_pc_q, resp_pc_q;
  logic [63:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  cnt_t          count_q, outstanding_q, discard_q;

  cnt_t credits_used;
  logic fifo_nonempty;
  logic grant, rsp, rsp_drop, push, pop;

  always_comb begin
    credits_used  = count_q + outstanding_q;
    fifo_nonempty = (count_q != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp           = imem_rvalid & (outstanding_q != '0);
    rsp_drop      = rsp & (discard_q != '0);
    push          = rsp & ~rsp_drop & ~redirect_valid;
  end

  assign imem_req  = reset & ~redirect_valid & (credits_used < cnt_t'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;

  assign out_valid = fifo_nonempty & ~redirect_valid;
  assign out_pc    = fifo_nonempty ? fifo_pc[rd_ptr_q] : 64'h0;
  assign out_instr = fifo_nonempty ? fifo_instr[rd_ptr_q] : 32'h0;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_q + cnt_t'(grant) - cnt_t'(rsp);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        // Everything still in flight after this cycle belongs to the old path.
        discard_q  <= outstanding_q - cnt_t'(rsp);
      end else begin
        if (grant) fetch_pc_q <= fetch_pc_q + 64'd4;
        if (push) begin
          resp_pc_q <= resp_pc_q + 64'd4;
          wr_ptr_q  <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q   <= count_q + cnt_t'(push) - cnt_t'(pop);
        discard_q <= discard_q - cnt_t'(rsp_drop);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= resp_pc_q;
      fifo_instr[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: queue-based reference model of
// in-flight requests and buffered instructions, driven by a latency-L memory.
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready = 1'b0;

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    bit          stale;
    int          due;
  } fl_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  fl_t         fl[$];
  ent_t        fifo[$];
  logic [63:0] m_fetch_pc = RESET_PC;
  bit          in_reset = 1'b1;
  bit          gnt_rand = 1'b0;
  int          cyc = 0;
  int unsigned lat = 1;
  int          total = 0;
  int          bad = 0;
  logic        exp_req, exp_valid;
  logic [161:0] obs_vec, exp_vec;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'hA5C3_0000;
  endfunction

  task automatic drive_mem();
    imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_rvalid = (fl.size() != 0) && (fl[0].due <= cyc);
    imem_rdata  = imem_rvalid ? instr_of(fl[0].addr) : $urandom;
  endtask

  // Drive memory, then sample DUT and build model expectations for this cycle.
  task automatic sample();
    logic [63:0] epc;
    logic [31:0] ein;
    drive_mem();
    #1;
    exp_req   = !in_reset && !redirect_valid && (fifo.size() + fl.size() < DEPTH);
    exp_valid = !in_reset && !redirect_valid && (fifo.size() != 0);
    epc = (fifo.size() != 0) ? fifo[0].pc : 64'h0;
    ein = (fifo.size() != 0) ? fifo[0].instr : 32'h0;
    exp_vec = {exp_req, m_fetch_pc, exp_valid, epc, ein};
    obs_vec = {imem_req, imem_addr, out_valid, out_pc, out_instr};
  endtask

  task automatic advance();
    fl_t r;
    bit  g, p;
    assert (!(imem_rvalid && fl.size() == 0))
      else $error("FAIL protocol rvalid with nothing outstanding");
    g = exp_req && imem_gnt;
    p = exp_valid && out_ready;
    if (redirect_valid) begin
      if (imem_rvalid) void'(fl.pop_front());
      fifo.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
    end else begin
      if (p) void'(fifo.pop_front());
      if (imem_rvalid) begin
        r = fl.pop_front();
        if (!r.stale) fifo.push_back('{r.addr, imem_rdata});
      end
      if (g) begin
        fl.push_back('{m_fetch_pc, 1'b0, cyc + int'(lat)});
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    in_reset = 1'b1;
    sample();
    total++;
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_vals dut=%h model=%h", obs_vec, exp_vec);
    end
    @(negedge clk);
    reset = 1'b1;
    in_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_seq();
    int first_v = -1;
    int n_valid = 0;
    lat = 1; gnt_rand = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL seq cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first_v < 0) first_v = i + 1;
      end
      advance();
    end
    total++;
    if (first_v != 3) begin
      bad++;
      $display("FAIL seq_first_valid got=%0d want=3", first_v);
    end
    total++;
    if (n_valid != 18) begin
      bad++;
      $display("FAIL seq_continuous got=%0d want=18", n_valid);
    end
  endtask

  task automatic test_backpressure();
    int g = 0;
    int p = 0;
    lat = 1; gnt_rand = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    sample();
    total++;
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL bp_flush dut=%h model=%h", obs_vec, exp_vec);
    end
    advance();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (imem_req && imem_gnt) g++;
      advance();
    end
    total++;
    if (g != 4) begin
      bad++;
      $display("FAIL bp_grants got=%0d want=4", g);
    end
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full req=%b valid=%b want req=0 valid=1", imem_req, out_valid);
    end
    out_ready = 1'b1;
    g = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL bp_drain cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (i < 4 && out_valid && out_ready) p++;
      if (imem_req && imem_gnt) g++;
      advance();
    end
    total++;
    if (p != 4 || g == 0) begin
      bad++;
      $display("FAIL bp_resume pops=%0d grants=%0d want pops=4 grants>0", p, g);
    end
  endtask

  task automatic test_redirect_l3();
    logic [63:0] nxt = 64'h100;
    int npop = 0;
    lat = 3; gnt_rand = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      redirect_valid = (i == 10);
      redirect_pc    = 64'h100;
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL redir_l3 cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (i > 10 && out_valid && out_ready) begin
        total++;
        if (out_pc !== nxt) begin
          bad++;
          $display("FAIL redir_l3_pc got=%h want=%h", out_pc, nxt);
        end
        nxt = nxt + 64'd4;
        npop++;
      end
      advance();
    end
    redirect_valid = 1'b0;
    total++;
    if (npop == 0) begin
      bad++;
      $display("FAIL redir_l3_progress got=0 pops want>0");
    end
  endtask

  task automatic test_redirect_rvalid();
    logic [63:0] nxt = 64'h200;
    lat = 3; gnt_rand = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      redirect_valid = (i == 8);
      redirect_pc    = 64'h200;
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL redir_rv cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (i == 8) begin
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
          bad++;
          $display("FAIL redir_rv_quiet req=%b valid=%b want 0 0", imem_req, out_valid);
        end
      end
      if (i == 9) begin
        total++;
        if (imem_addr !== 64'h200 || imem_req !== 1'b1) begin
          bad++;
          $display("FAIL redir_rv_addr got=%h req=%b want=200 req=1", imem_addr, imem_req);
        end
      end
      if (i > 8 && out_valid && out_ready) begin
        total++;
        if (out_pc !== nxt) begin
          bad++;
          $display("FAIL redir_rv_pc got=%h want=%h", out_pc, nxt);
        end
        nxt = nxt + 64'd4;
      end
      advance();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        pv_req = 1'b0, pv_gnt = 1'b0, pv_red = 1'b1;
    logic [63:0] pv_addr = 64'h0;
    lat = 2; gnt_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      out_ready      = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      if (redirect_valid)
        redirect_pc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 :
                      {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      if (!(pv_req && pv_gnt) && !pv_red) begin
        total++;
        if (imem_addr !== pv_addr) begin
          bad++;
          $display("FAIL addr_stable got=%h want=%h", imem_addr, pv_addr);
        end
      end
      pv_req = imem_req; pv_gnt = imem_gnt; pv_red = redirect_valid; pv_addr = imem_addr;
      advance();
    end
    redirect_valid = 1'b0;
    gnt_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat = 2; gnt_rand = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h300;
    sample();
    advance();
    redirect_valid = 1'b0;
    while (!(fifo.size() >= 2 && fl.size() >= 1) && n < 40) begin
      sample();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rstmid_fill cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      advance();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL rstmid_setup timed out fifo=%0d inflight=%0d", fifo.size(), fl.size());
    end
    #2;
    reset = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    obs_vec = {imem_req, imem_addr, out_valid, out_pc, out_instr};
    exp_vec = {1'b0, RESET_PC, 1'b0, 64'h0, 32'h0};
    total++;
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL rstmid_async dut=%h model=%h", obs_vec, exp_vec);
    end
    @(negedge clk);
    fl.delete();
    fifo.delete();
    m_fetch_pc = RESET_PC;
    reset = 1'b1;
    lat = 1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (i == 0) begin
        total++;
        if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin
          bad++;
          $display("FAIL rstmid_restart addr=%h req=%b want=%h req=1", imem_addr, imem_req,
                   RESET_PC);
        end
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rstmid_run cyc=%0d dut=%h model=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_redirect_l3();
    test_redirect_rvalid();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
